// File: rtl/serial_add_ctrl_pkg.sv
// ============================================================================
// Module      : serial_add_ctrl_pkg
// Description : Shared state encodings and parameter legality helper for the
//               serial adder/subtractor controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_add_ctrl_pkg;

    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // The datapath consumes two bits per step, so the operand width must split evenly.
    function automatic bit width_is_legal(input int w);
        return (w >= 2) && ((w % 2) == 0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/serial_add_ctrl_fa2_slice.sv
// ============================================================================
// Module      : fa2_slice
// Description : Two-bit ripple full-adder slice; exposes the internal carry
//               into bit 1 so the controller can derive signed overflow.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fa2_slice (
    input  logic [1:0] a,
    input  logic [1:0] b,
    input  logic       cin,
    output logic [1:0] s,
    output logic       c_mid,
    output logic       c_out
);

    always_comb begin
        s[0]  = a[0] ^ b[0] ^ cin;
        c_mid = (a[0] & b[0]) | (a[0] & cin) | (b[0] & cin);
        s[1]  = a[1] ^ b[1] ^ c_mid;
        c_out = (a[1] & b[1]) | (a[1] & c_mid) | (b[1] & c_mid);
    end

endmodule

`default_nettype wire

// File: rtl/serial_add_ctrl.sv
// ============================================================================
// Module      : serial_add_ctrl
// Description : Multi-cycle add/subtract controller driving one shared 2-bit
//               adder slice, LSB first, with valid/ready on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int             STEPS    = WIDTH / 2;
    localparam int             CNT_W    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEPS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    generate
        if (!width_is_legal(WIDTH)) begin : g_bad_width
            $error("serial_add_ctrl: WIDTH must be even and >= 2");
        end
    endgenerate

    state_t             r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_res;
    logic               r_carry;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;
    logic               r_ovf;

    logic [1:0]         w_s;
    logic               w_c_mid;
    logic               w_c_out;
    logic [WIDTH-1:0]   w_res_next;
    logic               w_last_step;

    fa2_slice u_slice (
        .a     (r_a[1:0]),
        .b     (r_b[1:0]),
        .cin   (r_carry),
        .s     (w_s),
        .c_mid (w_c_mid),
        .c_out (w_c_out)
    );

    // Result bits enter at the top so that after STEPS shifts bit 0 lands at the bottom.
    generate
        if (WIDTH == 2) begin : g_res_narrow
            assign w_res_next = w_s;
        end else begin : g_res_wide
            assign w_res_next = {w_s, r_res[WIDTH-1:2]};
        end
    endgenerate

    assign w_last_step = (r_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        // Subtraction is a + ~b + 1: invert b here and seed the carry with 1.
                        r_a     <= a;
                        r_b     <= sub ? ~b : b;
                        r_carry <= sub ? 1'b1 : cin;
                        r_cnt   <= CNT_LAST;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_a     <= r_a >> 2;
                    r_b     <= r_b >> 2;
                    r_res   <= w_res_next;
                    r_carry <= w_c_out;
                    r_cnt   <= r_cnt - CNT_ONE;
                    if (w_last_step) begin
                        // On the MSB slice c_mid is the carry into bit WIDTH-1.
                        r_sum   <= w_res_next;
                        r_cout  <= w_c_out;
                        r_ovf   <= w_c_mid ^ w_c_out;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
// ============================================================================
// Module      : tb_serial_add_ctrl
// Description : Scoreboard bench for serial_add_ctrl (WIDTH=16).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_add_ctrl;

    localparam int WIDTH = 16;
    localparam int STEPS = WIDTH / 2;
    localparam int N_RND = 200;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } res_t;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             in_valid  = 1'b0;
    logic             cin       = 1'b0;
    logic             sub       = 1'b0;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] a         = '0;
    logic [WIDTH-1:0] b         = '0;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    int   n_total = 0;
    int   n_bad   = 0;
    res_t sb[$];

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic res_t model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                                   input logic mcin, input logic msub);
        logic [WIDTH-1:0] bb;
        logic [WIDTH:0]   full;
        res_t             r;
        bb     = msub ? ~mb : mb;
        full   = {1'b0, ma} + {1'b0, bb} + {{WIDTH{1'b0}}, (msub ? 1'b1 : mcin)};
        r.sum  = full[WIDTH-1:0];
        r.cout = full[WIDTH];
        r.ovf  = (ma[WIDTH-1] == bb[WIDTH-1]) && (r.sum[WIDTH-1] != ma[WIDTH-1]);
        return r;
    endfunction

    task automatic pop_compare(input string tag);
        res_t e;
        check({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, "_sum"},  32'(sum),  32'(e.sum));
            check({tag, "_cout"}, 32'(cout), 32'(e.cout));
            check({tag, "_ovf"},  32'(ovf),  32'(e.ovf));
        end
    endtask

    task automatic run_directed(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_b,
                                input logic tcin, input logic tsub, input res_t exp, input int hold);
        int k;
        k = 0;
        while (!in_ready && k < 50) begin
            step();
            k++;
        end
        check("idle_ready", 32'(in_ready), 32'd1);
        a = ta; b = tb_b; cin = tcin; sub = tsub; in_valid = 1'b1;
        step();
        sb.push_back(exp);
        in_valid = 1'b0;
        a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        for (int i = 0; i < STEPS; i++) begin
            check("run_in_ready", 32'(in_ready), 32'd0);
            check("run_out_valid", 32'(out_valid), 32'd0);
            step();
        end
        check("latency_valid", 32'(out_valid), 32'd1);
        for (int i = 0; i < hold; i++) begin
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_sum", 32'(sum), 32'(exp.sum));
            in_valid = ~in_valid;
            a = WIDTH'($urandom);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        pop_compare("dir");
        step();
        out_ready = 1'b0;
        check("back_in_ready", 32'(in_ready), 32'd1);
        check("back_out_valid", 32'(out_valid), 32'd0);
        check("kept_sum", 32'(sum), 32'(exp.sum));
    endtask

    task automatic rnd_driver();
        logic [WIDTH-1:0] ta, tbv;
        logic             tc, ts;
        int               k;
        for (int n = 0; n < N_RND; n++) begin
            repeat ($urandom_range(0, 3)) step();
            ta = WIDTH'($urandom); tbv = WIDTH'($urandom);
            tc = 1'($urandom);     ts = 1'($urandom);
            a = ta; b = tbv; cin = tc; sub = ts; in_valid = 1'b1;
            k = 0;
            while (!in_ready && k < 200) begin
                step();
                k++;
            end
            if (k >= 200) check("drv_timeout", 32'd0, 32'd1);
            step();
            sb.push_back(model(ta, tbv, tc, ts));
            in_valid = 1'b0;
            a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        end
    endtask

    task automatic rnd_monitor();
        int got;
        int cyc;
        got = 0;
        cyc = 0;
        while (got < N_RND && cyc < 20000) begin
            out_ready = 1'($urandom_range(0, 1));
            if (out_valid && out_ready) begin
                pop_compare("rnd");
                got++;
            end
            step();
            cyc++;
        end
        out_ready = 1'b0;
        check("rnd_count", 32'(got), 32'(N_RND));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        rst_n = 1'b1;
        step();

        run_directed(16'h1234, 16'h4321, 1'b0, 1'b0, '{sum: 16'h5555, cout: 1'b0, ovf: 1'b0}, 0);
        run_directed(16'hFFFF, 16'h0001, 1'b1, 1'b0, '{sum: 16'h0001, cout: 1'b1, ovf: 1'b0}, 1);
        run_directed(16'h7FFF, 16'h0001, 1'b0, 1'b0, '{sum: 16'h8000, cout: 1'b0, ovf: 1'b1}, 0);
        run_directed(16'h0005, 16'h0007, 1'b1, 1'b1, '{sum: 16'hFFFE, cout: 1'b0, ovf: 1'b0}, 0);
        run_directed(16'h8000, 16'h0001, 1'b0, 1'b1, '{sum: 16'h7FFF, cout: 1'b1, ovf: 1'b1}, 5);

        // Abort an operation three steps into RUN.
        a = 16'h1111; b = 16'h2222; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (3) step();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_sum", 32'(sum), 32'd0);
        check("arst_cout", 32'(cout), 32'd0);
        check("arst_ovf", 32'(ovf), 32'd0);
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd1);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < STEPS + 4; i++) begin
            check("arst_no_pulse", 32'(out_valid), 32'd0);
            step();
        end
        run_directed(16'h0010, 16'h0020, 1'b0, 1'b0, '{sum: 16'h0030, cout: 1'b0, ovf: 1'b0}, 0);

        fork
            rnd_driver();
            rnd_monitor();
        join
        for (int i = 0; i < STEPS + 2; i++) begin
            check("tail_no_valid", 32'(out_valid), 32'd0);
            step();
        end
        check("tail_sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
